// File: rtl/skinny_dom1_pkg.sv
// Shared constants, FSM state type and bit-routing helpers for the masked SKINNY-8 inverse S-box.
package skinny_dom1_pkg;

  localparam int unsigned INV_SBOX8_LATENCY = 8;
  localparam int unsigned CntW = $clog2(INV_SBOX8_LATENCY);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} inv_sbox_state_e;

  // Input byte bit feeding network variable a<k>
  localparam int unsigned IdxA0 = 6;
  localparam int unsigned IdxA1 = 5;
  localparam int unsigned IdxA2 = 2;
  localparam int unsigned IdxA3 = 7;
  localparam int unsigned IdxA4 = 3;
  localparam int unsigned IdxA5 = 1;
  localparam int unsigned IdxA6 = 4;
  localparam int unsigned IdxA7 = 0;

  // Result bit produced by gate <k>, gates in evaluation order
  localparam int unsigned OutG0 = 2;
  localparam int unsigned OutG1 = 3;
  localparam int unsigned OutG2 = 7;
  localparam int unsigned OutG3 = 5;
  localparam int unsigned OutG4 = 1;
  localparam int unsigned OutG5 = 0;
  localparam int unsigned OutG6 = 6;
  localparam int unsigned OutG7 = 4;

  function automatic logic [7:0] map_in(input logic [7:0] i);
    logic [7:0] a;
    a[0] = i[IdxA0];
    a[1] = i[IdxA1];
    a[2] = i[IdxA2];
    a[3] = i[IdxA3];
    a[4] = i[IdxA4];
    a[5] = i[IdxA5];
    a[6] = i[IdxA6];
    a[7] = i[IdxA7];
    return a;
  endfunction

  function automatic logic [7:0] map_out(input logic [7:0] g);
    logic [7:0] b;
    b = '0;
    b[OutG0] = g[0];
    b[OutG1] = g[1];
    b[OutG2] = g[2];
    b[OutG3] = g[3];
    b[OutG4] = g[4];
    b[OutG5] = g[5];
    b[OutG6] = g[6];
    b[OutG7] = g[7];
    return b;
  endfunction

endpackage

// File: rtl/skinny_inv_sbox8_dom1_hs_if.sv
// Valid/ready handshake and share bus of the masked SKINNY-8 inverse S-box.
interface skinny_inv_sbox8_dom1_hs_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] si0;
  logic [7:0] si1;
  logic [7:0] r;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] bo0;
  logic [7:0] bo1;

  modport master (
    output in_valid, si0, si1, r, out_ready,
    input  in_ready, out_valid, bo0, bo1
  );

  modport slave (
    input  in_valid, si0, si1, r, out_ready,
    output in_ready, out_valid, bo0, bo1
  );
endinterface

// File: rtl/dom1_inv_cfn_gate.sv
// First-order DOM-indep gate computing f = nor(x,y) ^ z over two shares, two register stages.
module dom1_inv_cfn_gate (
  input  logic clk,
  input  logic rst,
  input  logic x0_i,
  input  logic x1_i,
  input  logic y0_i,
  input  logic y1_i,
  input  logic z0_i,
  input  logic z1_i,
  input  logic r_i,
  output logic f0_o,
  output logic f1_o,
  output logic f0_nxt_o,
  output logic f1_nxt_o
);

  (* keep = "true", dont_touch = "true" *) logic g0_q, g1_q, t0_q, t1_q, f0_q, f1_q;
  logic g0_d, g1_d, t0_d, t1_d, f0_d, f1_d;

  // Cross-share terms are refreshed with r_i before they are ever registered or combined.
  always_comb begin
    g0_d = (x0_i & y0_i) ^ z0_i;
    g1_d = (~x1_i & ~y1_i) ^ z1_i;
    t0_d = (~y1_i & x0_i) ^ r_i;
    t1_d = (~x1_i & y0_i) ^ r_i;
    f0_d = t0_q ^ g0_q;
    f1_d = t1_q ^ g1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g0_q <= 1'b0;
      g1_q <= 1'b0;
      t0_q <= 1'b0;
      t1_q <= 1'b0;
      f0_q <= 1'b0;
      f1_q <= 1'b0;
    end else begin
      g0_q <= g0_d;
      g1_q <= g1_d;
      t0_q <= t0_d;
      t1_q <= t1_d;
      f0_q <= f0_d;
      f1_q <= f1_d;
    end
  end

  assign f0_o     = f0_q;
  assign f1_o     = f1_q;
  assign f0_nxt_o = f0_d;
  assign f1_nxt_o = f1_d;

endmodule

// File: rtl/skinny_inv_sbox8_dom1_hs.sv
// Masked (DOM, first order) SKINNY-8 inverse S-box with valid/ready handshake, latency 8.
// SKINNY_INV_SBOX8_OUT_GATE_EN: registered output gate holding bo0/bo1 at 0 while out_valid=0.
module skinny_inv_sbox8_dom1_hs
  import skinny_dom1_pkg::*;
(
  input logic                              clk,
  input logic                              rst,
  skinny_inv_sbox8_dom1_hs_if.slave        bus_io
);

  inv_sbox_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_rdy, out_vld, accept, last_cyc;
  logic [7:0]      cap0_q, cap1_q, r_q;
  logic [7:0]      a_s0, a_s1, b_s0, b_s1;
  logic [7:0]      gx0, gx1, gy0, gy1, gz0, gz1, gf0, gf1, gn0, gn1;

  assign accept   = bus_io.in_valid & in_rdy;
  assign last_cyc = (state_q == StBusy) && (cnt_q == CntW'(INV_SBOX8_LATENCY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (last_cyc) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_rdy  = (state_q == StIdle);
    out_vld = (state_q == StDone);
  end

  assign bus_io.in_ready  = in_rdy;
  assign bus_io.out_valid = out_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap0_q <= '0;
      cap1_q <= '0;
      r_q    <= '0;
    end else if (accept) begin
      cap0_q <= bus_io.si0;
      cap1_q <= bus_io.si1;
      r_q    <= bus_io.r;
    end
  end

  assign a_s0 = map_in(cap0_q);
  assign a_s1 = map_in(cap1_q);
  assign b_s0 = map_out(gf0);
  assign b_s1 = map_out(gf1);

  // Operand routing, gate 7 down to gate 0; gates 4..7 consume earlier levels' registered shares.
  assign gx0 = {b_s0[7], b_s0[2], b_s0[3], a_s0[1], a_s0[0], a_s0[2], a_s0[3], a_s0[4]};
  assign gx1 = {b_s1[7], b_s1[2], b_s1[3], a_s1[1], a_s1[0], a_s1[2], a_s1[3], a_s1[4]};
  assign gy0 = {b_s0[6], b_s0[1], b_s0[2], b_s0[3], a_s0[1], a_s0[3], a_s0[0], a_s0[5]};
  assign gy1 = {b_s1[6], b_s1[1], b_s1[2], b_s1[3], a_s1[1], a_s1[3], a_s1[0], a_s1[5]};
  assign gz0 = {a_s0[0], a_s0[2], a_s0[1], a_s0[4], a_s0[3], a_s0[5], a_s0[6], a_s0[7]};
  assign gz1 = {a_s1[0], a_s1[2], a_s1[1], a_s1[4], a_s1[3], a_s1[5], a_s1[6], a_s1[7]};

  for (genvar i = 0; i < 8; i++) begin : g_gate
    dom1_inv_cfn_gate u_gate (
      .clk      (clk),
      .rst      (rst),
      .x0_i     (gx0[i]),
      .x1_i     (gx1[i]),
      .y0_i     (gy0[i]),
      .y1_i     (gy1[i]),
      .z0_i     (gz0[i]),
      .z1_i     (gz1[i]),
      .r_i      (r_q[i]),
      .f0_o     (gf0[i]),
      .f1_o     (gf1[i]),
      .f0_nxt_o (gn0[i]),
      .f1_nxt_o (gn1[i])
    );
  end

`ifdef SKINNY_INV_SBOX8_OUT_GATE_EN
  logic [7:0] bo0_q, bo0_d, bo1_q, bo1_d;
  logic [2:0] unused_b0, unused_b1;

  // Loads the gates' next values on the edge entering DONE so bo appears with out_valid.
  always_comb begin
    bo0_d = '0;
    bo1_d = '0;
    if (last_cyc) begin
      bo0_d = map_out(gn0);
      bo1_d = map_out(gn1);
    end else if (out_vld && !bus_io.out_ready) begin
      bo0_d = bo0_q;
      bo1_d = bo1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bo0_q <= '0;
      bo1_q <= '0;
    end else begin
      bo0_q <= bo0_d;
      bo1_q <= bo1_d;
    end
  end

  assign bus_io.bo0 = bo0_q;
  assign bus_io.bo1 = bo1_q;
  assign unused_b0  = {b_s0[5], b_s0[4], b_s0[0]};
  assign unused_b1  = {b_s1[5], b_s1[4], b_s1[0]};
`else
  logic [7:0] unused_n0, unused_n1;

  assign bus_io.bo0 = b_s0;
  assign bus_io.bo1 = b_s1;
  assign unused_n0  = gn0;
  assign unused_n1  = gn1;
`endif

endmodule

// File: tb/tb_skinny_inv_sbox8_dom1_hs.sv
// Randomised self-checking bench: masked inverse S-box checked against a forward S-box model.
module tb_skinny_inv_sbox8_dom1_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  logic [7:0] res;
  logic [7:0] inv_tbl [256];

  skinny_inv_sbox8_dom1_hs_if bus ();

  skinny_inv_sbox8_dom1_hs dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Forward SKINNY-8 S-box, obtained by undoing the inverse network from its last gate back.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic a0, a1, a2, a3, a4, a5, a6, a7;
    a0 = x[4] ^ ~(x[7] | x[6]);
    a2 = x[6] ^ ~(x[2] | x[1]);
    a1 = x[0] ^ ~(x[3] | x[2]);
    a4 = x[1] ^ ~(a1 | x[3]);
    a3 = x[5] ^ ~(a0 | a1);
    a5 = x[7] ^ ~(a2 | a3);
    a6 = x[3] ^ ~(a3 | a0);
    a7 = x[2] ^ ~(a4 | a5);
    return {a3, a0, a1, a6, a4, a2, a5, a7};
  endfunction

  task automatic run_txn(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] rv,
                         input int hold, input bit keep_valid, output logic [7:0] r_out);
    int lat;
    logic [7:0] h0, h1;
    bus.in_valid  = 1'b1;
    bus.si0       = s0;
    bus.si1       = s1;
    bus.r         = rv;
    bus.out_ready = 1'b0;
    check_eq("in_ready_idle", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = keep_valid;
    bus.si0      = 8'($urandom);
    bus.si1      = 8'($urandom);
    bus.r        = 8'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 16) begin
      check_eq("in_ready_busy", 32'(bus.in_ready), 0);
`ifdef SKINNY_INV_SBOX8_OUT_GATE_EN
      check_eq("bo_gated_busy", 32'({bus.bo0, bus.bo1}), 0);
`endif
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    bus.out_ready = 1'b0;
    check_eq("latency", lat, 8);
    h0    = bus.bo0;
    h1    = bus.bo1;
    r_out = h0 ^ h1;
    for (int i = 0; i < hold; i++) begin
      bus.si0 = 8'($urandom);
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(bus.out_valid), 1);
      check_eq("hold_ready", 32'(bus.in_ready), 0);
      check_eq("hold_bo", 32'({bus.bo0, bus.bo1}), 32'({h0, h1}));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq("post_valid", 32'(bus.out_valid), 0);
    check_eq("post_ready", 32'(bus.in_ready), 1);
`ifdef SKINNY_INV_SBOX8_OUT_GATE_EN
    check_eq("bo_gated_idle", 32'({bus.bo0, bus.bo1}), 0);
`endif
  endtask

  initial begin
    int seen;
    logic [7:0] m, rv, v;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.si0       = '0;
    bus.si1       = '0;
    bus.r         = '0;
    for (int x = 0; x < 256; x++) inv_tbl[fwd_sbox(8'(x))] = 8'(x);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(bus.in_ready), 1);
    check_eq("rst_valid", 32'(bus.out_valid), 0);
    check_eq("rst_bo", 32'({bus.bo0, bus.bo1}), 0);
    rst = 1'b0;
    #1;
    check_eq("rel_ready", 32'(bus.in_ready), 1);
    check_eq("rel_valid", 32'(bus.out_valid), 0);

    // Known answers
    run_txn(8'h65, 8'h00, 8'h00, 0, 1'b0, res);
    check_eq("kat_65", 32'(res), 32'h00);
    run_txn(8'h4C ^ 8'hA5, 8'hA5, 8'h5A, 2, 1'b0, res);
    check_eq("kat_4c", 32'(res), 32'h01);

    // Long stall in DONE with in_valid held high
    v = 8'($urandom);
    m = 8'($urandom);
    run_txn(v ^ m, m, 8'($urandom), 20, 1'b1, res);
    check_eq("stall_result", 32'(res), 32'(inv_tbl[v]));

    // Reset while BUSY at counter 4
    bus.si0      = 8'h12;
    bus.si1      = 8'h34;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", 32'(bus.in_ready), 1);
    check_eq("midrst_valid", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check_eq("midrst_no_valid", seen, 0);
    v = 8'($urandom);
    m = 8'($urandom);
    run_txn(v ^ m, m, 8'($urandom), 1, 1'b0, res);
    check_eq("midrst_next", 32'(res), 32'(inv_tbl[v]));

    // Every value under random masks, round-tripped through the forward model
    for (int x = 0; x < 256; x++) begin
      m  = 8'($urandom);
      rv = 8'($urandom);
      run_txn(8'(x) ^ m, m, rv, $urandom_range(0, 2), 1'b0, res);
      check_eq("roundtrip", 32'(fwd_sbox(res)), x);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/skinny_inv_sbox8_dom1_hs.md
SKINNY_INV_SBOX8_DOM1_HS -- requirements
Module: skinny_inv_sbox8_dom1_hs

Interface
REQ-001 clk  input  1  single clock, all registers on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  input shares and mask are valid.
REQ-004 in_ready  output  1  block can accept an input.
REQ-005 si0  input  8  share 0 of the S-box output byte to invert.
REQ-006 si1  input  8  share 1 of the S-box output byte to invert.
REQ-007 r  input  8  fresh mask bits, one per masked gate, fresh for every accepted input.
REQ-008 out_valid  output  1  result shares are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 bo0  output  8  share 0 of the inverse S-box result.
REQ-011 bo1  output  8  share 1 of the inverse S-box result.

Function
REQ-012 Unmasked value: bo0^bo1 SHALL equal the SKINNY-8 inverse S-box of si0^si1.
REQ-013 Datapath: 8 first-order DOM-indep masked core gates, f = nor(x,y) xor z, inverting the forward network.
- Level 1: b2=a7^nor(a4,a5), b3=a6^nor(a3,a0), b7=a5^nor(a2,a3), b5=a3^nor(a0,a1).
- Level 2: b1=a4^nor(a1,b3), b0=a1^nor(b3,b2).
- Level 3: b6=a2^nor(b2,b1).
- Level 4: b4=a0^nor(b7,b6).
- Input mapping: a0=i6, a1=i5, a2=i2, a3=i7, a4=i3, a5=i1, a6=i4, a7=i0; result bit k = bk.
REQ-014 Gate, per shared inputs x,y,z and mask bit rk, stage 1 registered:
- g1=(~x1&~y1)^z1, g0=(x0&y0)^z0.
- t1=(~x1&y0)^rk, t0=(~y1&x0)^rk.
- Stage 2 registered: f=t^g per share.
- No share-0/share-1 combination without a registered mask.
REQ-015 Mask bits r[0..7] SHALL map to gates in the order of REQ-013.
REQ-016 FSM states:
- IDLE: in_ready=1.
- BUSY: in_ready=0; 3-bit cycle counter.
- DONE: out_valid=1.
REQ-017 Accept = in_valid & in_ready. On the accept edge, si0, si1 and r SHALL be captured into internal registers, FSM goes IDLE->BUSY, counter=0.
REQ-018 Captured registers SHALL hold until the next accept; external inputs may change after accept.
REQ-019 BUSY: counter increments each edge; on the 8th edge after accept, FSM goes to DONE with out_valid=1 (fixed latency 8).
REQ-020 DONE: bo0/bo1 stable; out_valid & out_ready -> IDLE on that edge; out_valid held while out_ready=0, indefinitely.
REQ-021 in_valid SHALL be ignored in BUSY and DONE; there is no back-to-back accept from DONE.
REQ-022 out_ready SHALL be ignored outside DONE.

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE, counter=0, and all capture, gate and output registers to 0; in_ready=1 and out_valid=0 after release.
REQ-024 Reset in BUSY or DONE SHALL discard the transaction with no out_valid pulse.

Configuration
REQ-025 Macro SKINNY_INV_SBOX8_OUT_GATE_EN.
- Defined: bo0/bo1 SHALL read 0 whenever out_valid=0, using a registered gate with no combinational share mixing.
- Undefined: bo0/bo1 expose the level-4/level-1.. gate registers directly and are meaningful only when out_valid=1.

Structure
REQ-026 Package skinny_dom1_pkg SHALL hold:
- INV_SBOX8_LATENCY=8.
- FSM state typedef.
- Input/output bit-index constants of REQ-013.
REQ-027 One sub-module dom1_inv_cfn_gate SHALL implement REQ-014 and be instantiated 8 times, with register-removal and resource-sharing optimisation disabled on all share registers.

Verification
REQ-028 Scenario 1:
- Stimulus: si0=0x65, si1=0x00, r=0x00, then out_ready=1.
- Required response: out_valid exactly 8 edges after accept; bo0^bo1=0x00.
REQ-029 Scenario 2:
- Stimulus: si0=0x4C^0xA5, si1=0xA5, r=0x5A.
- Required response: bo0^bo1=0x01.
REQ-030 Scenario 3:
- Stimulus: all 256 values x random masks/r, result fed to a forward S-box reference model.
- Required response: round-trip identity for every value.
REQ-031 Scenario 4:
- Stimulus: out_ready=0 for 20 cycles in DONE; in_valid=1 throughout.
- Required response: out_valid and bo stable; in_ready=0; no second accept.
REQ-032 Scenario 5:
- Stimulus: rst pulsed at BUSY counter=4.
- Required response: immediate IDLE; in_ready=1; no out_valid; next transaction correct.
REQ-033 Scenario 6:
- Stimulus: under SKINNY_INV_SBOX8_OUT_GATE_EN, inputs as scenario 2.
- Required response: bo0=bo1=0x00 whenever out_valid=0.
